// File: rtl/perf_stat_dump.sv
// Performance-statistics unit: counts core events until halt, then streams the
// frozen counters out as 16-bit beats over a valid/ready handshake.
module perf_stat_dump #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWrite,
  input  logic        memWrite,
  input  logic        halt,
  input  logic        iCacheReq,
  input  logic        iCacheHit,
  input  logic        dCacheReq,
  input  logic        dCacheHit,
  input  logic        outReady,
  output logic        outValid,
  output logic [15:0] outData,
  output logic [2:0]  outId,
  output logic        outLast,
  output logic        done,
  output logic        hitNoReqErr
);

  localparam int BEATS = CNT_W / 16;
  localparam int SW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0]    SLICE_TOP = SW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_COUNT,
    S_DUMP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [6];
  logic [SW-1:0]    r_slice;

  logic [5:0]       w_inc;
  logic [CNT_W-1:0] w_cnt_nxt [6];
  logic             w_hit_err;
  logic             w_last_slice;
  logic [2:0]       w_nid;
  logic [SW-1:0]    w_nslice;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != CNT_MAX)) return v + CNT_ONE;
    return v;
  endfunction

  function automatic logic [15:0] slice16(input logic [CNT_W-1:0] v,
                                          input logic [SW-1:0] s);
    return v[16*s +: 16];
  endfunction

  always_comb begin
    w_inc[0] = 1'b1;
    w_inc[1] = regWrite | memWrite | halt;
    w_inc[2] = iCacheReq;
    w_inc[3] = iCacheHit & iCacheReq;
    w_inc[4] = dCacheReq;
    w_inc[5] = dCacheHit & dCacheReq;
    for (int i = 0; i < 6; i++) begin
      w_cnt_nxt[i] = sat_inc(r_cnt[i], w_inc[i]);
    end
    w_hit_err = (iCacheHit & ~iCacheReq) | (dCacheHit & ~dCacheReq);
  end

  // Next beat position: walk slices high to low, then move to the next counter.
  always_comb begin
    w_last_slice = (r_slice == '0);
    w_nid        = w_last_slice ? (outId + 3'd1) : outId;
    w_nslice     = w_last_slice ? SLICE_TOP : (r_slice - SW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COUNT;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
      r_slice     <= '0;
      outValid    <= 1'b0;
      outData     <= '0;
      outId       <= '0;
      outLast     <= 1'b0;
      done        <= 1'b0;
      hitNoReqErr <= 1'b0;
    end else begin
      case (r_state)
        S_COUNT: begin
          for (int i = 0; i < 6; i++) r_cnt[i] <= w_cnt_nxt[i];
          if (w_hit_err) hitNoReqErr <= 1'b1;
          if (halt) begin
            // First beat comes from the post-increment value so the halt cycle is included.
            r_state  <= S_DUMP;
            outValid <= 1'b1;
            outId    <= 3'd0;
            r_slice  <= SLICE_TOP;
            outData  <= slice16(w_cnt_nxt[0], SLICE_TOP);
            outLast  <= 1'b0;
          end
        end
        S_DUMP: begin
          if (outReady) begin
            if (outLast) begin
              r_state  <= S_DONE;
              outValid <= 1'b0;
              outLast  <= 1'b0;
              done     <= 1'b1;
            end else begin
              outId   <= w_nid;
              r_slice <= w_nslice;
              outData <= slice16(r_cnt[w_nid], w_nslice);
              outLast <= (w_nid == 3'd5) && (w_nslice == '0);
            end
          end
        end
        S_DONE: begin
          outValid <= 1'b0;
          outLast  <= 1'b0;
          done     <= 1'b1;
        end
        default: r_state <= S_COUNT;
      endcase
    end
  end

endmodule
